// File: rtl/cpu_wb.sv
// cpu_wb: writeback stage. Sole driver of the register-file write port.
// It picks the MEM-stage result (ALU, extended load or link PC+8). Late mult/div
// results wait in a small in-order FIFO and drain into idle pipeline slots.
// A starvation counter stalls the pipeline when queued results cannot drain.
// Optional build macro: WB_RETIRE_CNT_EN adds the wb_retire_cnt output, which
// counts retired register writes.
module cpu_wb #(
  parameter int MD_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        mem_reg_write_en,
  input  logic [4:0]  mem_reg_write_num,
  input  logic [1:0]  mem_wb_src,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic [2:0]  mem_load_type,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_pc,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_reg_num,
  input  logic [31:0] md_data,
  output logic        md_pending,
  output logic        wb_stall,
  output logic        wb_reg_write_en,
  output logic [4:0]  wb_reg_write_num,
  output logic [31:0] wb_reg_write_data
`ifdef WB_RETIRE_CNT_EN
  ,output logic [31:0] wb_retire_cnt
`endif
);

  localparam int PTR_W    = (MD_FIFO_DEPTH > 2) ? $clog2(MD_FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(MD_FIFO_DEPTH + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(MD_FIFO_DEPTH);
  localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

  // Source encodings
  localparam logic [1:0] SRC_LOAD = 2'd1;
  localparam logic [1:0] SRC_LINK = 2'd2;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  // FIFO storage (no reset, plain RAM) and control state
  logic [4:0]          fifo_num  [MD_FIFO_DEPTH];
  logic [31:0]         fifo_data [MD_FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [STARVE_W-1:0] starve_reg, starve_next;
  logic                stall_reg;

  logic        slot_write;
  logic        enq, deq;
  logic [7:0]  byte_lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;
  logic [31:0] slot_data;

  assign md_ready   = (count_reg != DEPTH_C);
  assign md_pending = (count_reg != '0);
  assign wb_stall   = stall_reg;

  // A stalled stage ignores the MEM slot entirely. Writes to $0 are dropped.
  assign slot_write = mem_reg_write_en && (mem_reg_write_num != 5'd0) && !stall_reg;
  // Queued results only use slots that the pipeline leaves idle.
  // The decision uses the registered count, so a result never falls through an empty FIFO.
  assign deq = !slot_write && (count_reg != '0);
  // Results aimed at $0 complete the handshake but are not stored.
  assign enq = md_valid && md_ready && (md_reg_num != 5'd0);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lane[gi] = mem_load_data[8*gi +: 8];
  end

  assign sel_byte = byte_lane[mem_addr_lo];
  assign sel_half = mem_addr_lo[1] ? mem_load_data[31:16] : mem_load_data[15:0];

  // Load extension: select the lane, then sign- or zero-extend it
  always_comb begin
    load_ext = mem_load_data;
    case (mem_load_type)
      LT_LB:   load_ext = {{24{sel_byte[7]}}, sel_byte};
      LT_LBU:  load_ext = {24'd0, sel_byte};
      LT_LH:   load_ext = {{16{sel_half[15]}}, sel_half};
      LT_LHU:  load_ext = {16'd0, sel_half};
      default: load_ext = mem_load_data;
    endcase
  end

  // Write-data source select. The reserved encoding falls back to the ALU result.
  always_comb begin
    slot_data = mem_alu_result;
    case (mem_wb_src)
      SRC_LOAD: slot_data = load_ext;
      SRC_LINK: slot_data = mem_pc + 32'd8;
      default:  slot_data = mem_alu_result;
    endcase
  end

  // Starvation count: counts blocked cycles and saturates at the limit
  always_comb begin
    starve_next = starve_reg;
    if ((count_reg == '0) || deq)
      starve_next = '0;
    else if (starve_reg != LIMIT_C)
      starve_next = starve_reg + STARVE_W'(1);
  end

  // FIFO payload write
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_num[wr_ptr_reg]  <= md_reg_num;
      fifo_data[wr_ptr_reg] <= md_data;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (deq) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Starvation counter and stall: stall is set when the limit is hit and held until the FIFO is empty
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      starve_reg <= '0;
      stall_reg  <= 1'b0;
    end else begin
      starve_reg <= starve_next;
      if (count_reg == '0)
        stall_reg <= 1'b0;
      else if (starve_next == LIMIT_C)
        stall_reg <= 1'b1;
    end
  end

  // Register-file write port. The pipeline slot wins over a queued result.
  // num and data hold their values while the port is idle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wb_reg_write_en   <= 1'b0;
      wb_reg_write_num  <= 5'd0;
      wb_reg_write_data <= 32'd0;
    end else if (slot_write) begin
      wb_reg_write_en   <= 1'b1;
      wb_reg_write_num  <= mem_reg_write_num;
      wb_reg_write_data <= slot_data;
    end else if (deq) begin
      wb_reg_write_en   <= 1'b1;
      wb_reg_write_num  <= fifo_num[rd_ptr_reg];
      wb_reg_write_data <= fifo_data[rd_ptr_reg];
    end else begin
      wb_reg_write_en   <= 1'b0;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Retired-write counter: counts every cycle in which the write port is enabled
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      wb_retire_cnt <= 32'd0;
    else if (wb_reg_write_en)
      wb_retire_cnt <= wb_retire_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cpu_wb.sv
// tb_cpu_wb: directed bench for cpu_wb with default parameters (FIFO depth 4, starve limit 8).
// Expected register writes are queued in a scoreboard in issue order.
// A negedge monitor pops the scoreboard and compares every observed write.
module tb_cpu_wb;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        mem_reg_write_en;
  logic [4:0]  mem_reg_write_num;
  logic [1:0]  mem_wb_src;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_pc;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg_num;
  logic [31:0] md_data;
  logic        md_pending;
  logic        wb_stall;
  logic        wb_reg_write_en;
  logic [4:0]  wb_reg_write_num;
  logic [31:0] wb_reg_write_data;

  int tests = 0;
  int fails = 0;
  logic [36:0] sb [$];
  logic [36:0] mon_exp;

  always #5 clk = ~clk;

  cpu_wb dut (
    .clk               (clk),
    .clr_n             (clr_n),
    .mem_reg_write_en  (mem_reg_write_en),
    .mem_reg_write_num (mem_reg_write_num),
    .mem_wb_src        (mem_wb_src),
    .mem_alu_result    (mem_alu_result),
    .mem_load_data     (mem_load_data),
    .mem_load_type     (mem_load_type),
    .mem_addr_lo       (mem_addr_lo),
    .mem_pc            (mem_pc),
    .md_valid          (md_valid),
    .md_ready          (md_ready),
    .md_reg_num        (md_reg_num),
    .md_data           (md_data),
    .md_pending        (md_pending),
    .wb_stall          (wb_stall),
    .wb_reg_write_en   (wb_reg_write_en),
    .wb_reg_write_num  (wb_reg_write_num),
    .wb_reg_write_data (wb_reg_write_data)
  );

  // Scoreboard monitor: each write seen on the port must match the oldest expected write
  always @(negedge clk) begin
    if (clr_n === 1'b1 && wb_reg_write_en === 1'b1) begin
      tests++;
      $display("[TB] write num=%0d data=%h", wb_reg_write_num, wb_reg_write_data);
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_write observed num=%0d data=%h expected no write",
               wb_reg_write_num, wb_reg_write_data);
      end
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        assert ({wb_reg_write_num, wb_reg_write_data} === mon_exp) else begin
          fails++;
          $error("FAIL sb_write observed num=%0d data=%h expected num=%0d data=%h",
                 wb_reg_write_num, wb_reg_write_data, mon_exp[36:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a writing pipeline slot and queue its expected result
  task automatic pipe(input logic [4:0] num, input logic [1:0] src, input logic [31:0] alu,
                      input logic [31:0] ld, input logic [2:0] lt, input logic [1:0] lo,
                      input logic [31:0] pc, input logic [31:0] exp);
    mem_reg_write_en  = 1'b1;
    mem_reg_write_num = num;
    mem_wb_src        = src;
    mem_alu_result    = alu;
    mem_load_data     = ld;
    mem_load_type     = lt;
    mem_addr_lo       = lo;
    mem_pc            = pc;
    if (num != 5'd0) sb.push_back({num, exp});
  endtask

  task automatic idle();
    mem_reg_write_en  = 1'b0;
    mem_reg_write_num = 5'd0;
  endtask

  logic [2:0]  ld_type [6];
  logic [1:0]  ld_lo   [6];
  logic [31:0] ld_exp  [6];

  initial begin
    ld_type = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    ld_lo   = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3};
    ld_exp  = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};

    clr_n = 1'b0;
    mem_reg_write_en = 1'b0; mem_reg_write_num = 5'd0; mem_wb_src = 2'd0;
    mem_alu_result = 32'd0; mem_load_data = 32'd0; mem_load_type = 3'd0;
    mem_addr_lo = 2'd0; mem_pc = 32'd0;
    md_valid = 1'b0; md_reg_num = 5'd0; md_data = 32'd0;

    // Reset state
    step(); step();
    chk("rst_en", {31'd0, wb_reg_write_en}, 32'd0);
    chk("rst_num", {27'd0, wb_reg_write_num}, 32'd0);
    chk("rst_data", wb_reg_write_data, 32'd0);
    chk("rst_stall", {31'd0, wb_stall}, 32'd0);
    chk("rst_pending", {31'd0, md_pending}, 32'd0);
    chk("rst_ready", {31'd0, md_ready}, 32'd1);
    clr_n = 1'b1;
    step();
    chk("post_rst_idle", {31'd0, wb_reg_write_en}, 32'd0);

    // ALU write, latency 1
    pipe(5'd8, 2'd0, 32'h12345678, 32'h0, 3'd0, 2'd0, 32'h0, 32'h12345678);
    step();
    chk("alu_en", {31'd0, wb_reg_write_en}, 32'd1);
    chk("alu_num", {27'd0, wb_reg_write_num}, 32'd8);
    chk("alu_data", wb_reg_write_data, 32'h12345678);

    // Loads from word 0x80FF7F01; the ALU value differs so a wrong select shows up
    for (int i = 0; i < 6; i++) begin
      pipe(5'(9 + i), 2'd1, 32'hDEADBEEF, 32'h80FF7F01, ld_type[i], ld_lo[i], 32'h0, ld_exp[i]);
      step();
      chk("load_data", wb_reg_write_data, ld_exp[i]);
    end

    // Link write
    pipe(5'd31, 2'd2, 32'h0, 32'h0, 3'd0, 2'd0, 32'h00400010, 32'h00400018);
    step();
    chk("link_data", wb_reg_write_data, 32'h00400018);

    // A write to $0 is dropped; num and data hold their previous values
    pipe(5'd0, 2'd0, 32'hCAFEF00D, 32'h0, 3'd0, 2'd0, 32'h0, 32'h0);
    step();
    chk("r0_en", {31'd0, wb_reg_write_en}, 32'd0);
    chk("r0_hold_num", {27'd0, wb_reg_write_num}, 32'd31);
    chk("r0_hold_data", wb_reg_write_data, 32'h00400018);

    // Reserved source selects ALU; link PC wraps modulo 2^32
    pipe(5'd5, 2'd3, 32'h00000055, 32'h11111111, 3'd0, 2'd0, 32'h100, 32'h00000055);
    step();
    pipe(5'd6, 2'd2, 32'h0, 32'h0, 3'd0, 2'd0, 32'hFFFFFFFC, 32'h00000004);
    step();
    idle();
    step();
    chk("idle_en", {31'd0, wb_reg_write_en}, 32'd0);

    // Arbitration: md accepted while the pipeline writes three cycles in a row
    pipe(5'd10, 2'd0, 32'h1, 32'h0, 3'd0, 2'd0, 32'h0, 32'h1);
    md_valid = 1'b1; md_reg_num = 5'd2; md_data = 32'hAA;
    step();
    md_valid = 1'b0;
    chk("arb_pending_a", {31'd0, md_pending}, 32'd1);
    pipe(5'd11, 2'd0, 32'h2, 32'h0, 3'd0, 2'd0, 32'h0, 32'h2);
    step();
    pipe(5'd12, 2'd0, 32'h3, 32'h0, 3'd0, 2'd0, 32'h0, 32'h3);
    step();
    chk("arb_pending_c", {31'd0, md_pending}, 32'd1);
    chk("arb_num_c", {27'd0, wb_reg_write_num}, 32'd12);
    sb.push_back({5'd2, 32'hAA});
    idle();
    step();
    chk("arb_md_en", {31'd0, wb_reg_write_en}, 32'd1);
    chk("arb_md_num", {27'd0, wb_reg_write_num}, 32'd2);
    chk("arb_md_data", wb_reg_write_data, 32'hAA);
    chk("arb_pending_d", {31'd0, md_pending}, 32'd0);

    // Empty FIFO has no fall-through: write appears 2 cycles after the handshake
    md_valid = 1'b1; md_reg_num = 5'd3; md_data = 32'hBB;
    sb.push_back({5'd3, 32'hBB});
    step();
    md_valid = 1'b0;
    chk("nft_en_e", {31'd0, wb_reg_write_en}, 32'd0);
    chk("nft_pending", {31'd0, md_pending}, 32'd1);
    step();
    chk("nft_en_f", {31'd0, wb_reg_write_en}, 32'd1);
    chk("nft_data_f", wb_reg_write_data, 32'hBB);

    // md result to $0: accepted but never enqueued
    md_valid = 1'b1; md_reg_num = 5'd0; md_data = 32'hCC;
    step();
    md_valid = 1'b0;
    chk("md_r0_pending", {31'd0, md_pending}, 32'd0);
    step();
    chk("md_r0_en", {31'd0, wb_reg_write_en}, 32'd0);

    // Fill the FIFO during continuous pipeline writes
    for (int i = 0; i < 4; i++) begin
      pipe(5'd1, 2'd0, 32'h1000 + i, 32'h0, 3'd0, 2'd0, 32'h0, 32'h1000 + i);
      md_valid = 1'b1; md_reg_num = 5'(20 + i); md_data = 32'h100 + i;
      chk("fill_ready", {31'd0, md_ready}, 32'd1);
      step();
    end
    chk("full_ready", {31'd0, md_ready}, 32'd0);
    chk("full_pending", {31'd0, md_pending}, 32'd1);
    // A fifth result is offered at full and must not be accepted
    md_reg_num = 5'd24; md_data = 32'h1FF;
    for (int j = 0; j < 4; j++) begin
      pipe(5'd1, 2'd0, 32'h1004 + j, 32'h0, 3'd0, 2'd0, 32'h0, 32'h1004 + j);
      step();
      md_valid = 1'b0;
      chk("starve_no_stall", {31'd0, wb_stall}, 32'd0);
    end
    chk("full_ready_hold", {31'd0, md_ready}, 32'd0);
    pipe(5'd1, 2'd0, 32'h1008, 32'h0, 3'd0, 2'd0, 32'h0, 32'h1008);
    step();
    chk("starve_stall", {31'd0, wb_stall}, 32'd1);

    // Under stall the MEM slot is ignored; FIFO drains on consecutive cycles
    for (int k = 0; k < 4; k++) sb.push_back({5'(20 + k), 32'h100 + k});
    mem_reg_write_en = 1'b1; mem_reg_write_num = 5'd9; mem_wb_src = 2'd0; mem_alu_result = 32'h999;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_en", {31'd0, wb_reg_write_en}, 32'd1);
      chk("drain_num", {27'd0, wb_reg_write_num}, 32'(20 + k));
    end
    chk("drain_pending", {31'd0, md_pending}, 32'd0);
    chk("drain_ready", {31'd0, md_ready}, 32'd1);
    chk("drain_stall_hold", {31'd0, wb_stall}, 32'd1);
    step();
    chk("unstall", {31'd0, wb_stall}, 32'd0);
    chk("unstall_no_write", {31'd0, wb_reg_write_en}, 32'd0);
    idle();
    step();

    // Reset mid-operation with three queued entries and one write in flight
    for (int i = 0; i < 3; i++) begin
      pipe(5'd7, 2'd0, 32'h700 + i, 32'h0, 3'd0, 2'd0, 32'h0, 32'h700 + i);
      if (i == 2) void'(sb.pop_back());
      md_valid = 1'b1; md_reg_num = 5'(25 + i); md_data = 32'h500 + i;
      step();
    end
    md_valid = 1'b0;
    idle();
    chk("pre_rst_pending", {31'd0, md_pending}, 32'd1);
    clr_n = 1'b0;
    #1;
    chk("mid_rst_en", {31'd0, wb_reg_write_en}, 32'd0);
    chk("mid_rst_num", {27'd0, wb_reg_write_num}, 32'd0);
    chk("mid_rst_data", wb_reg_write_data, 32'd0);
    chk("mid_rst_pending", {31'd0, md_pending}, 32'd0);
    chk("mid_rst_ready", {31'd0, md_ready}, 32'd1);
    chk("mid_rst_stall", {31'd0, wb_stall}, 32'd0);
    step();
    clr_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_no_write", {31'd0, wb_reg_write_en}, 32'd0);
    end

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
